// File: rtl/seg7_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
// Shared definitions for common-anode 7-segment readers.
//   - SEG_CA_0..SEG_CA_9 : active-low segment patterns, bit order {a,b,c,d,e,f,g}
//   - SEG_CA_BLANK       : all segments off
//   - DIG_TENS/DIG_ONES  : bit positions of the anode enables in dig_en_n
//   - frame_state_t      : frame assembly states of the scan reader
//   - bcd2_to_bin        : two BCD digits to a 7-bit binary value
// -----------------------------------------------------------------------------
package seg7_pkg;

    localparam logic [6:0] SEG_CA_0     = 7'h01;
    localparam logic [6:0] SEG_CA_1     = 7'h4F;
    localparam logic [6:0] SEG_CA_2     = 7'h12;
    localparam logic [6:0] SEG_CA_3     = 7'h06;
    localparam logic [6:0] SEG_CA_4     = 7'h4C;
    localparam logic [6:0] SEG_CA_5     = 7'h24;
    localparam logic [6:0] SEG_CA_6     = 7'h20;
    localparam logic [6:0] SEG_CA_7     = 7'h0F;
    localparam logic [6:0] SEG_CA_8     = 7'h00;
    localparam logic [6:0] SEG_CA_9     = 7'h04;
    localparam logic [6:0] SEG_CA_BLANK = 7'h7F;

    localparam int DIG_TENS = 1;
    localparam int DIG_ONES = 0;

    typedef enum logic [1:0] {
        F_EMPTY  = 2'd0,
        F_HAVE_T = 2'd1,
        F_HAVE_O = 2'd2
    } frame_state_t;

    // tens*10 + ones as tens*8 + tens*2 + ones; max 99 fits in 7 bits.
    function automatic logic [6:0] bcd2_to_bin(input logic [3:0] tens,
                                               input logic [3:0] ones);
        return {tens, 3'b000} + {2'b00, tens, 1'b0} + {3'b000, ones};
    endfunction

endpackage

// File: rtl/seg7_ca_decoder.sv
// -----------------------------------------------------------------------------
// seg7_ca_decoder
// Combinational decode of an active-low common-anode segment pattern to BCD.
//   i_seg     : segments {a,b,c,d,e,f,g}, active-low
//   o_digit   : decoded digit 0-9 (0 when illegal)
//   o_illegal : pattern is not one of the ten digit shapes (blank included)
// -----------------------------------------------------------------------------
module seg7_ca_decoder
    import seg7_pkg::*;
(
    input  logic [6:0] i_seg,
    output logic [3:0] o_digit,
    output logic       o_illegal
);

    always_comb begin
        o_digit   = 4'd0;
        o_illegal = 1'b0;
        case (i_seg)
            SEG_CA_0: o_digit = 4'd0;
            SEG_CA_1: o_digit = 4'd1;
            SEG_CA_2: o_digit = 4'd2;
            SEG_CA_3: o_digit = 4'd3;
            SEG_CA_4: o_digit = 4'd4;
            SEG_CA_5: o_digit = 4'd5;
            SEG_CA_6: o_digit = 4'd6;
            SEG_CA_7: o_digit = 4'd7;
            SEG_CA_8: o_digit = 4'd8;
            SEG_CA_9: o_digit = 4'd9;
            default:  o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg7_ca_scan_reader.sv
// -----------------------------------------------------------------------------
// seg7_ca_scan_reader
// Recovers a two-digit 0-99 value from a multiplexed common-anode display bus.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// F_EMPTY  | no digit captured since the last frame (or error / reset)
// F_HAVE_T | tens digit captured and pending, waiting for the ones digit
// F_HAVE_O | ones digit captured and pending, waiting for the tens digit
//
// Ports
//   clk       : system clock
//   rst_n     : asynchronous active-low reset
//   seg_in    : {dp,a,b,c,d,e,f,g}, active-low, dp ignored
//   dig_en_n  : active-low anode enables, [1] tens, [0] ones
//   tens_out  : last accepted tens digit
//   ones_out  : last accepted ones digit
//   num_out   : tens_out*10 + ones_out
//   num_valid : one-cycle pulse when the outputs above update
//   seg_err   : one-cycle pulse when a qualified capture is not a legal digit
// -----------------------------------------------------------------------------
module seg7_ca_scan_reader
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES = 4     // legal range 1-255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] seg_in,
    input  logic [1:0] dig_en_n,
    output logic [3:0] tens_out,
    output logic [3:0] ones_out,
    output logic [6:0] num_out,
    output logic       num_valid,
    output logic       seg_err
);

    localparam logic [7:0] STAB_FIRE = 8'(STABLE_CYCLES - 1);

    logic [9:0]   r_sync1;
    logic [9:0]   r_sync2;
    logic [8:0]   r_prev;
    logic [7:0]   r_stab;
    frame_state_t r_state;
    logic [3:0]   r_pend;
    logic [3:0]   r_tens;
    logic [3:0]   r_ones;
    logic [6:0]   r_num;
    logic         r_valid;
    logic         r_err;

    logic [8:0]   w_cur;
    logic         w_unused_dp;
    logic         w_same;
    logic         w_fire;
    logic         w_tens_sel;
    logic         w_ones_sel;
    logic         w_capture;
    logic [3:0]   w_digit;
    logic         w_illegal;

    // Reset to all-ones so the synchronizer looks like a blank bus.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
        end else begin
            r_sync1 <= {dig_en_n, seg_in};
            r_sync2 <= r_sync1;
        end
    end

    // The decimal point never takes part in stability or decode.
    assign w_cur       = {r_sync2[9:8], r_sync2[6:0]};
    assign w_unused_dp = r_sync2[7];

    // Counter resets to saturated so nothing fires until the bus moves.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev <= '1;
            r_stab <= '1;
        end else begin
            r_prev <= w_cur;
            if (!w_same) begin
                r_stab <= 8'd0;
            end else if (r_stab != 8'hFF) begin
                r_stab <= r_stab + 8'd1;
            end
        end
    end

    assign w_same = (w_cur == r_prev);

    // Counter walks past STAB_FIRE once per dwell, so this fires only once.
    assign w_fire = w_same && (r_stab == STAB_FIRE);

    assign w_tens_sel = !w_cur[7 + DIG_TENS] &&  w_cur[7 + DIG_ONES];
    assign w_ones_sel = !w_cur[7 + DIG_ONES] &&  w_cur[7 + DIG_TENS];
    assign w_capture  = w_fire && (w_tens_sel || w_ones_sel);

    seg7_ca_decoder u_decoder (
        .i_seg     (w_cur[6:0]),
        .o_digit   (w_digit),
        .o_illegal (w_illegal)
    );

    // A single pending register suffices: the state says which digit it holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= F_EMPTY;
            r_pend  <= 4'd0;
            r_tens  <= 4'd0;
            r_ones  <= 4'd0;
            r_num   <= 7'd0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            if (w_capture) begin
                if (w_illegal) begin
                    r_err   <= 1'b1;
                    r_state <= F_EMPTY;
                end else begin
                    case (r_state)
                        F_EMPTY: begin
                            r_pend  <= w_digit;
                            r_state <= w_tens_sel ? F_HAVE_T : F_HAVE_O;
                        end
                        F_HAVE_T: begin
                            if (w_tens_sel) begin
                                r_pend <= w_digit;
                            end else begin
                                r_tens  <= r_pend;
                                r_ones  <= w_digit;
                                r_num   <= bcd2_to_bin(r_pend, w_digit);
                                r_valid <= 1'b1;
                                r_state <= F_EMPTY;
                            end
                        end
                        F_HAVE_O: begin
                            if (w_ones_sel) begin
                                r_pend <= w_digit;
                            end else begin
                                r_tens  <= w_digit;
                                r_ones  <= r_pend;
                                r_num   <= bcd2_to_bin(w_digit, r_pend);
                                r_valid <= 1'b1;
                                r_state <= F_EMPTY;
                            end
                        end
                        default: r_state <= F_EMPTY;
                    endcase
                end
            end
        end
    end

    assign tens_out  = r_tens;
    assign ones_out  = r_ones;
    assign num_out   = r_num;
    assign num_valid = r_valid;
    assign seg_err   = r_err;

endmodule

// File: tb/tb_seg7_ca_scan_reader.sv
module tb_seg7_ca_scan_reader;

    localparam int S    = 4;
    localparam int NCYC = 2048;

    localparam logic [1:0] EN_T = 2'b01;   // tens anode low
    localparam logic [1:0] EN_O = 2'b10;   // ones anode low
    localparam logic [1:0] EN_B = 2'b11;   // blank
    localparam logic [1:0] EN_C = 2'b00;   // contention

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] seg_in;
    logic [1:0] dig_en_n;
    logic [3:0] tens_out;
    logic [3:0] ones_out;
    logic [6:0] num_out;
    logic       num_valid;
    logic       seg_err;

    always #5 clk = ~clk;

    seg7_ca_scan_reader #(.STABLE_CYCLES(S)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .seg_in    (seg_in),
        .dig_en_n  (dig_en_n),
        .tens_out  (tens_out),
        .ones_out  (ones_out),
        .num_out   (num_out),
        .num_valid (num_valid),
        .seg_err   (seg_err)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    // Digit shapes, independent of the design package.
    logic [6:0] seg_tab [10] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C,
                                 7'h24, 7'h20, 7'h0F, 7'h00, 7'h04};

    // Expected pulse schedule, indexed by clock edge number.
    bit exp_nv [NCYC];
    bit exp_se [NCYC];
    int ev_t   [NCYC];
    int ev_o   [NCYC];

    // Model: expected visible outputs and digits gathered since the last frame.
    int cur_t = 0, cur_o = 0, cur_n = 0;
    bit m_have_t = 0, m_have_o = 0;
    int m_t = 0, m_o = 0;

    int nv_cnt = 0, se_cnt = 0, first_nv = -1;
    int last_start = 0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Every-cycle comparison against the model.
    int cc;
    bit e_nv, e_se;
    always begin
        @(posedge clk);
        #1;
        cc   = cyc;
        e_nv = (cc < NCYC) ? exp_nv[cc] : 1'b0;
        e_se = (cc < NCYC) ? exp_se[cc] : 1'b0;
        if (e_nv) begin
            cur_t = ev_t[cc];
            cur_o = ev_o[cc];
            cur_n = ev_t[cc] * 10 + ev_o[cc];
        end
        tests++;
        if (num_valid !== e_nv || seg_err !== e_se || int'(tens_out) != cur_t ||
            int'(ones_out) != cur_o || int'(num_out) != cur_n) begin
            fails++;
            $display("FAIL cycle_cmp @%0d: got nv=%b err=%b t=%0d o=%0d n=%0d expected nv=%b err=%b t=%0d o=%0d n=%0d",
                     cc, num_valid, seg_err, tens_out, ones_out, num_out,
                     e_nv, e_se, cur_t, cur_o, cur_n);
        end
        if (num_valid === 1'b1) begin
            nv_cnt++;
            if (first_nv < 0) first_nv = cc;
        end
        if (seg_err === 1'b1) se_cnt++;
    end

    task automatic complete(input int t);
        exp_nv[t] = 1'b1;
        ev_t[t]   = m_t;
        ev_o[t]   = m_o;
        m_have_t  = 0;
        m_have_o  = 0;
    endtask

    // Hold {en, seg} for n clock edges. A held digit is reported S+3 edges
    // after it is first driven, which needs it to still be on the bus S+1
    // edges after being driven.
    task automatic apply(input logic [1:0] en, input logic [6:0] seg, input int n);
        int t, d;
        @(negedge clk);
        dig_en_n   = en;
        seg_in     = {1'($urandom_range(1)), seg};
        last_start = cyc;
        if (n >= S + 1 && (en == EN_T || en == EN_O)) begin
            t = cyc + S + 3;
            d = -1;
            for (int i = 0; i < 10; i++) if (seg_tab[i] == seg) d = i;
            if (t < NCYC) begin
                if (d < 0) begin
                    exp_se[t] = 1'b1;
                    m_have_t  = 0;
                    m_have_o  = 0;
                end else if (en == EN_T) begin
                    m_t = d;
                    m_have_t = 1;
                    if (m_have_o) complete(t);
                end else begin
                    m_o = d;
                    m_have_o = 1;
                    if (m_have_t) complete(t);
                end
            end
        end
        repeat (n) @(posedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n    = 1'b0;
        dig_en_n = EN_B;
        seg_in   = 8'hFF;
        m_have_t = 0;
        m_have_o = 0;
        cur_t = 0; cur_o = 0; cur_n = 0;
        @(posedge clk);
        #1;
        check("rst_num", int'(num_out), 0);
        check("rst_tens", int'(tens_out), 0);
        check("rst_ones", int'(ones_out), 0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n    = 1'b0;
        dig_en_n = EN_B;
        seg_in   = 8'hFF;
        @(posedge clk);
        #1;
        check("por_num", int'(num_out), 0);
        check("por_valid", int'(num_valid), 0);
        check("por_err", int'(seg_err), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic frame "2","5"
        apply(EN_T, 7'h12, 10);
        apply(EN_O, 7'h24, 10);
        check("basic_latency", first_nv - last_start, 7);
        check("basic_num", int'(num_out), 25);
        check("basic_tens", int'(tens_out), 2);
        check("basic_ones", int'(ones_out), 5);

        // Short "9" dwell between "4" and "7"
        apply(EN_T, 7'h4C, 10);
        apply(EN_O, 7'h04, 3);
        apply(EN_O, 7'h0F, 10);
        check("short_num", int'(num_out), 47);

        // Tens "1" then illegal blank ones; outputs hold, then "3","0"
        apply(EN_T, 7'h4F, 10);
        apply(EN_O, 7'h7F, 10);
        check("illegal_hold", int'(num_out), 47);
        check("illegal_err_cnt", se_cnt, 1);
        apply(EN_T, 7'h06, 10);
        apply(EN_O, 7'h01, 10);
        check("after_err_num", int'(num_out), 30);

        // Overwrite ones "8"->"6", then tens "9"
        apply(EN_O, 7'h00, 10);
        apply(EN_O, 7'h20, 10);
        apply(EN_T, 7'h04, 10);
        check("overwrite_num", int'(num_out), 96);
        check("valid_cnt_4", nv_cnt, 4);

        // Pending "5" survives contention and blank dwells, then ones "4"
        apply(EN_T, 7'h24, 10);
        apply(EN_C, 7'h12, 10);
        apply(EN_B, 7'h24, 10);
        apply(EN_C, 7'h55, 10);
        check("contention_err_cnt", se_cnt, 1);
        apply(EN_O, 7'h4C, 10);
        check("contention_num", int'(num_out), 54);

        // Tens "5" captured, reset, ones "3" alone must not complete a frame
        apply(EN_T, 7'h24, 10);
        do_reset();
        apply(EN_O, 7'h06, 10);
        apply(EN_B, 7'h7F, 10);
        check("post_reset_num", int'(num_out), 0);
        check("valid_cnt_5", nv_cnt, 5);
        apply(EN_T, 7'h00, 10);
        check("post_reset_frame", int'(num_out), 83);

        apply(EN_B, 7'h7F, 10);
        repeat (5) @(posedge clk);
        #2;
        check("final_valid_cnt", nv_cnt, 6);
        check("final_err_cnt", se_cnt, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
